// File: rtl/yuv_pkg.sv
// Shared colour-space constants and types for the video generator datapath.
//   - YUV->RGB coefficients (BT.601 full range, 8 fractional bits)
//   - RGB->grey luma weights (77/150/29, sum 256)
//   - pix24_t: one packed 24-bit pixel, three 8-bit channels MSB-first
//   - clamp_u8: saturate a signed 19-bit result into 0..255
package yuv_pkg;

    localparam int unsigned COEF_KRV = 359;  // 1.402 * 256
    localparam int unsigned COEF_KGU = 88;   // 0.344 * 256
    localparam int unsigned COEF_KGV = 183;  // 0.714 * 256
    localparam int unsigned COEF_KBU = 454;  // 1.772 * 256

    localparam int unsigned OFFSET_UV = 128;

    localparam int unsigned GREY_KR = 77;
    localparam int unsigned GREY_KG = 150;
    localparam int unsigned GREY_KB = 29;

    typedef struct packed {
        logic [7:0] c_hi;   // Y or R
        logic [7:0] c_mid;  // U or G
        logic [7:0] c_lo;   // V or B
    } pix24_t;

    function automatic logic [7:0] clamp_u8(input logic signed [18:0] v);
        logic [7:0] res;
        if (v < 19'sd0) begin
            res = 8'd0;
        end else if (v > 19'sd255) begin
            res = 8'hFF;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/yuv2rgb.sv
// Streaming YUV (BT.601 full range) to RGB converter, 3-stage pipeline.
//   clk_i            pixel clock
//   rst_n_i          asynchronous active-low reset
//   color_conv_en_i  1 = converted pipeline output, 0 = combinational bypass
//   color_data_i     {Y, U, V}, color_data_vld_i qualifies it
//   color_data_o     {R, G, B}, color_data_vld_o qualifies it
// The pipeline always runs; the enable only selects the output source.
module yuv2rgb
    import yuv_pkg::*;
#(
    parameter int unsigned COEF_FRAC = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        color_conv_en_i,
    input  logic [23:0] color_data_i,
    input  logic        color_data_vld_i,
    output logic [23:0] color_data_o,
    output logic        color_data_vld_o
);

    localparam int unsigned D_W    = 9;                   // signed chroma delta
    localparam int unsigned PROD_W = D_W + COEF_FRAC + 1; // 18
    localparam int unsigned SUM_W  = PROD_W + 1;          // 19

    localparam logic signed [PROD_W-1:0] K_RV    = PROD_W'(COEF_KRV);
    localparam logic signed [PROD_W-1:0] K_GU    = PROD_W'(COEF_KGU);
    localparam logic signed [PROD_W-1:0] K_GV    = PROD_W'(COEF_KGV);
    localparam logic signed [PROD_W-1:0] K_BU    = PROD_W'(COEF_KBU);
    localparam logic signed [PROD_W-1:0] Y_ROUND = PROD_W'(2 ** (COEF_FRAC - 1));

    pix24_t w_yuv;
    assign w_yuv = color_data_i;

    // Stage 1: luma and offset-removed chroma
    logic signed [D_W-1:0] w_du, w_dv;
    assign w_du = D_W'(w_yuv.c_mid) - D_W'(OFFSET_UV);
    assign w_dv = D_W'(w_yuv.c_lo)  - D_W'(OFFSET_UV);

    logic [7:0]            r_s1_y;
    logic signed [D_W-1:0] r_s1_du, r_s1_dv;
    logic                  r_s1_vld;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s1_y   <= '0;
            r_s1_du  <= '0;
            r_s1_dv  <= '0;
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_y   <= w_yuv.c_hi;
            r_s1_du  <= w_du;
            r_s1_dv  <= w_dv;
            r_s1_vld <= color_data_vld_i;
        end
    end

    // Stage 2: coefficient products and rounded, scaled luma
    logic signed [PROD_W-1:0] w_p_rv, w_p_gu, w_p_gv, w_p_bu, w_y_base;
    assign w_p_rv   = PROD_W'(r_s1_dv) * K_RV;
    assign w_p_gu   = PROD_W'(r_s1_du) * K_GU;
    assign w_p_gv   = PROD_W'(r_s1_dv) * K_GV;
    assign w_p_bu   = PROD_W'(r_s1_du) * K_BU;
    assign w_y_base = (PROD_W'(r_s1_y) << COEF_FRAC) + Y_ROUND;

    logic signed [PROD_W-1:0] r_s2_p_rv, r_s2_p_gu, r_s2_p_gv, r_s2_p_bu, r_s2_y_base;
    logic                     r_s2_vld;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s2_p_rv   <= '0;
            r_s2_p_gu   <= '0;
            r_s2_p_gv   <= '0;
            r_s2_p_bu   <= '0;
            r_s2_y_base <= '0;
            r_s2_vld    <= 1'b0;
        end else begin
            r_s2_p_rv   <= w_p_rv;
            r_s2_p_gu   <= w_p_gu;
            r_s2_p_gv   <= w_p_gv;
            r_s2_p_bu   <= w_p_bu;
            r_s2_y_base <= w_y_base;
            r_s2_vld    <= r_s1_vld;
        end
    end

    // Stage 3: sum, arithmetic shift back to integer, saturate
    logic signed [SUM_W-1:0] w_r_sum, w_g_sum, w_b_sum;
    logic signed [SUM_W-1:0] w_r_sh, w_g_sh, w_b_sh;
    assign w_r_sum = SUM_W'(r_s2_y_base) + SUM_W'(r_s2_p_rv);
    assign w_g_sum = SUM_W'(r_s2_y_base) - SUM_W'(r_s2_p_gu) - SUM_W'(r_s2_p_gv);
    assign w_b_sum = SUM_W'(r_s2_y_base) + SUM_W'(r_s2_p_bu);
    assign w_r_sh  = w_r_sum >>> COEF_FRAC;
    assign w_g_sh  = w_g_sum >>> COEF_FRAC;
    assign w_b_sh  = w_b_sum >>> COEF_FRAC;

    pix24_t r_s3_pix;
    logic   r_s3_vld;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s3_pix <= '0;
            r_s3_vld <= 1'b0;
        end else begin
            r_s3_pix.c_hi  <= clamp_u8(w_r_sh);
            r_s3_pix.c_mid <= clamp_u8(w_g_sh);
            r_s3_pix.c_lo  <= clamp_u8(w_b_sh);
            r_s3_vld       <= r_s2_vld;
        end
    end

    // Output select: bypass is a pure wire path with zero latency
    assign color_data_o     = color_conv_en_i ? r_s3_pix : color_data_i;
    assign color_data_vld_o = color_conv_en_i ? r_s3_vld : color_data_vld_i;

endmodule

// File: tb/tb_yuv2rgb.sv
// Directed and streaming checks for yuv2rgb; outputs sampled on the falling edge.
module tb_yuv2rgb;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        color_conv_en_i;
    logic [23:0] color_data_i;
    logic        color_data_vld_i;
    logic [23:0] color_data_o;
    logic        color_data_vld_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    yuv2rgb #(.COEF_FRAC(8)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .color_conv_en_i  (color_conv_en_i),
        .color_data_i     (color_data_i),
        .color_data_vld_i (color_data_vld_i),
        .color_data_o     (color_data_o),
        .color_data_vld_o (color_data_vld_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sat8(input int v);
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    // Golden integer model of the BT.601 full-range conversion
    function automatic logic [23:0] yuv_model(input logic [23:0] p);
        int y, du, dv, r, g, b;
        y  = int'(p[23:16]);
        du = int'(p[15:8]) - 128;
        dv = int'(p[7:0]) - 128;
        r  = (y * 256 + 359 * dv + 128) >>> 8;
        g  = (y * 256 - 88 * du - 183 * dv + 128) >>> 8;
        b  = (y * 256 + 454 * du + 128) >>> 8;
        return {sat8(r), sat8(g), sat8(b)};
    endfunction

    // Single-pixel pulse at the current negedge; checks vld at t+1..t+4 and data at t+3
    task automatic run_pixel(input string tag, input logic [23:0] yuv, input logic [23:0] exp);
        color_data_i     = yuv;
        color_data_vld_i = 1'b1;
        @(negedge clk_i);
        color_data_vld_i = 1'b0;
        color_data_i     = 24'h0;
        check({tag, "_vld_t1"}, 32'(color_data_vld_o), 32'd0);
        @(negedge clk_i);
        check({tag, "_vld_t2"}, 32'(color_data_vld_o), 32'd0);
        @(negedge clk_i);
        check({tag, "_vld_t3"}, 32'(color_data_vld_o), 32'd1);
        check({tag, "_data"},   32'(color_data_o), 32'(exp));
        @(negedge clk_i);
        check({tag, "_vld_t4"}, 32'(color_data_vld_o), 32'd0);
    endtask

    logic [23:0] stream_in [16];

    initial begin
        rst_n_i          = 1'b0;
        color_conv_en_i  = 1'b1;
        color_data_i     = 24'h0;
        color_data_vld_i = 1'b0;

        repeat (3) @(negedge clk_i);
        check("rst_vld",  32'(color_data_vld_o), 32'd0);
        check("rst_data", 32'(color_data_o), 32'h000000);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_vld",  32'(color_data_vld_o), 32'd0);
        check("post_rst_data", 32'(color_data_o), 32'h000000);

        run_pixel("grey",     24'h808080, 24'h808080);
        run_pixel("clamp_hi", 24'hFF80FF, 24'hFFA4FF);
        run_pixel("clamp_lo", 24'h000000, 24'h008800);
        run_pixel("red",      24'h4C55FF, 24'hFE0000);

        // Back-to-back stream: output at negedge n belongs to input driven at n-3
        for (int i = 0; i < 16; i++) stream_in[i] = 24'($urandom);
        for (int n = 0; n < 19; n++) begin
            if (n >= 3) begin
                check("stream_vld",  32'(color_data_vld_o), 32'd1);
                check("stream_data", 32'(color_data_o), 32'(yuv_model(stream_in[n-3])));
            end else begin
                check("stream_lead_vld", 32'(color_data_vld_o), 32'd0);
            end
            if (n < 16) begin
                color_data_i     = stream_in[n];
                color_data_vld_i = 1'b1;
            end else begin
                color_data_i     = 24'h0;
                color_data_vld_i = 1'b0;
            end
            @(negedge clk_i);
        end
        check("stream_tail_vld", 32'(color_data_vld_o), 32'd0);

        // Bypass: combinational, same cycle
        color_conv_en_i  = 1'b0;
        color_data_i     = 24'h123456;
        color_data_vld_i = 1'b1;
        #1;
        check("byp_data", 32'(color_data_o), 32'h123456);
        check("byp_vld",  32'(color_data_vld_o), 32'd1);
        @(negedge clk_i);
        color_data_i     = 24'hABCDEF;
        color_data_vld_i = 1'b0;
        #1;
        check("byp_data_novld", 32'(color_data_o), 32'hABCDEF);
        check("byp_vld_novld",  32'(color_data_vld_o), 32'd0);
        @(negedge clk_i);

        // Toggle back on with vld held low; stale pixels drain within 3 cycles
        color_conv_en_i = 1'b1;
        color_data_i    = 24'h0;
        repeat (3) @(negedge clk_i);
        check("toggle_drain_vld", 32'(color_data_vld_o), 32'd0);

        // Async reset with pixels in flight
        color_data_i     = 24'h808080;
        color_data_vld_i = 1'b1;
        @(negedge clk_i);
        color_data_i     = 24'hFF80FF;
        @(negedge clk_i);
        color_data_vld_i = 1'b0;
        color_data_i     = 24'h0;
        @(negedge clk_i);
        check("pre_rst_vld",  32'(color_data_vld_o), 32'd1);
        check("pre_rst_data", 32'(color_data_o), 32'h808080);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async_rst_vld",  32'(color_data_vld_o), 32'd0);
        check("async_rst_data", 32'(color_data_o), 32'h000000);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check("no_stale_vld", 32'(color_data_vld_o), 32'd0);
        end
        run_pixel("after_rst", 24'h4C55FF, 24'hFE0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
